regfile_wb: RTL and testbench
=============================

# regfile_wb

Write-back end of the RA→RO→WB pipeline: consumes the decoded register write address, result and flags, and commits them to a 16-entry × 24-bit register file and a 4-bit flags register. Provides two read ports with same-cycle write bypass and a per-register pending-write scoreboard. Issue logic uses the scoreboard to stall on read-after-write hazards. Sits at the tail of the pipeline, fed by the latched outputs of the RO stage and read by decode.

## Interface
- `NREGS`, 16: register count; address width is 4, fixed.
- `DW`, 24: data width.
- `CW`, 2: scoreboard counter width; at most 3 outstanding writes per register.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `wb_enable_in`  in  1  write-back slot valid this cycle.
- `wb_we_in`  in  1  instruction writes a register.
- `wb_flags_we_in`  in  1  instruction writes flags.
- `wb_waddr_in`  in  4  destination register from RA stage.
- `wb_result_in`  in  24  value to commit.
- `wb_flags_in`  in  4  flags to commit.
- `iss_valid_in`  in  1  decode issues an instruction that will write a register.
- `iss_waddr_in`  in  4  its destination.
- `iss_ready_out`  out  1  scoreboard can accept the issue.
- `raddr_a_in`, `raddr_b_in`  in  4  read addresses.
- `rdata_a_out`, `rdata_b_out`  out  24  read data, combinational.
- `busy_a_out`, `busy_b_out`  out  1  read register has an uncommitted pending write.
- `flags_out`  out  4  architectural flags.

## Operation
- Commit: `commit = wb_enable_in & wb_we_in`; on commit, `regs[wb_waddr_in] <= wb_result_in`. All 16 registers are ordinary; R0 is writable.
- Flags: `wb_enable_in & wb_flags_we_in` → `flags <= wb_flags_in`. Independent of `wb_we_in`.
- Read: `rdata_x = (commit && raddr_x == wb_waddr_in) ? wb_result_in : regs[raddr_x]`.
- Scoreboard: one CW-bit counter per register, `cnt[r]`.
  - inc = `iss_valid_in & iss_ready_out` at `iss_waddr_in`.
  - dec = `commit` at `wb_waddr_in`.
  - Inc and dec on the same register in the same cycle: no change. On different registers, both apply.
  - `iss_ready_out = (cnt[iss_waddr_in] != 3) | (commit & wb_waddr_in == iss_waddr_in)`.
  - Commit with `cnt == 0` is a protocol error. The counter holds at 0 and does not wrap. The register write still occurs.
- Busy: `busy_x = cnt[raddr_x] != 0`, except when `cnt[raddr_x] == 1` and a commit to `raddr_x` is occurring this cycle; then busy is 0, because the bypass supplies the data.

## Timing
- Reset, sampled on the clock edge: all `regs` = 0, `flags` = 0, all `cnt` = 0.
  - Consequences: `rdata_*_out` = 0 (absent commit), `busy_*_out` = 0, `iss_ready_out` = 1, `flags_out` = 0.
  - Reset overrides a simultaneous commit or issue.
- Write latency: 0 cycles through the bypass; the register array updates on the edge. The read in the next cycle returns the new value from `regs`.
- Flags latency: 1 cycle; `flags_out` has no bypass.
- Scoreboard latency: counters update on the edge. `busy` reflects an issue from the next cycle onward.
- `wb_*` inputs are ignored when `wb_enable_in` = 0. `iss_waddr_in` is ignored when `iss_valid_in` = 0.
- Reset mid-operation discards all pending counts. Commits from instructions in flight before the reset are not counted and fall into the `cnt == 0` error case above.

## Structure
- Shared package: `REG_AW` = 4, `DW` = 24, `FLAGS_W` = 4, `SB_MAX` = 3.
- One sub-module, `reg_scoreboard`: counters, ready logic and busy logic, with 2 busy query ports.
- The register array and bypass stay in `regfile_wb`.

## Test plan
- Reset, then read all 16 addresses: every `rdata` = 0, `busy` = 0, `iss_ready_out` = 1, `flags_out` = 0.
- Commit R5 = 24'hABCDEF with `raddr_a` = 5 in the same cycle: `rdata_a` = 24'hABCDEF in that cycle and the next.
- Issue to R3 three times: `busy` for R3 rises the cycle after the first issue. After the third, `iss_ready_out` = 0 for R3. A fourth issue combined with a same-cycle commit to R3 is accepted and `cnt` stays 3.
- `cnt[R7]` = 1, commit R7 = 24'h000042 with `raddr_b` = 7: `busy_b` = 0 and `rdata_b` = 24'h000042 in the same cycle; `cnt[R7]` = 0 afterwards.
- Flags commit with `wb_we_in` = 0 and flags 4'b1010: `flags_out` = 4'b1010 the next cycle; no register changes and no `cnt` decrement.
- Issue to R2 twice, assert `rst` for one cycle, then commit to R2: `cnt[R2]` stays 0, the register is written, and `busy` stays 0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared widths and types for the write-back register file and its scoreboard.
// Imported by the interface, the scoreboard and the top level.
package regfile_wb_pkg;

    localparam int REG_AW  = 4;
    localparam int DW      = 24;
    localparam int FLAGS_W = 4;
    localparam int SB_MAX  = 3;

    typedef logic [REG_AW-1:0]  raddr_t;
    typedef logic [DW-1:0]      data_t;
    typedef logic [FLAGS_W-1:0] flags_t;

endpackage

// File: rtl/regfile_wb_if.sv
// Bundle of write-back, issue and read-port signals between the pipeline
// (master) and the register file (slave).
interface regfile_wb_if;
    import regfile_wb_pkg::*;

    logic   wb_enable_in;
    logic   wb_we_in;
    logic   wb_flags_we_in;
    raddr_t wb_waddr_in;
    data_t  wb_result_in;
    flags_t wb_flags_in;

    logic   iss_valid_in;
    raddr_t iss_waddr_in;
    logic   iss_ready_out;

    raddr_t raddr_a_in;
    raddr_t raddr_b_in;
    data_t  rdata_a_out;
    data_t  rdata_b_out;
    logic   busy_a_out;
    logic   busy_b_out;
    flags_t flags_out;

    modport master (
        output wb_enable_in, wb_we_in, wb_flags_we_in, wb_waddr_in, wb_result_in, wb_flags_in,
        output iss_valid_in, iss_waddr_in, raddr_a_in, raddr_b_in,
        input  iss_ready_out, rdata_a_out, rdata_b_out, busy_a_out, busy_b_out, flags_out
    );

    modport slave (
        input  wb_enable_in, wb_we_in, wb_flags_we_in, wb_waddr_in, wb_result_in, wb_flags_in,
        input  iss_valid_in, iss_waddr_in, raddr_a_in, raddr_b_in,
        output iss_ready_out, rdata_a_out, rdata_b_out, busy_a_out, busy_b_out, flags_out
    );

endinterface

// File: rtl/regfile_wb_reg_scoreboard.sv
// Per-register pending-write counters: incremented on accepted issue,
// decremented on commit, with issue back-pressure and two busy query ports.
module reg_scoreboard
    import regfile_wb_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int CW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         commit_i,
    input  raddr_t       wb_waddr_i,
    input  logic         iss_valid_i,
    input  raddr_t       iss_waddr_i,
    output logic         iss_ready_o,
    input  raddr_t [1:0] qaddr_i,
    output logic   [1:0] busy_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(SB_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q [NREGS];
    logic [CW-1:0] cnt_d [NREGS];
    logic          iss_fire;

    // Saturating step: a commit against an empty counter holds at zero.
    function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c,
                                               input logic          inc,
                                               input logic          dec);
        if (inc && !dec) return (c == CNT_MAX) ? c : c + 1'b1;
        if (dec && !inc) return (c == '0) ? c : c - 1'b1;
        return c;
    endfunction

    always_comb begin
        iss_ready_o = (cnt_q[iss_waddr_i] != CNT_MAX) ||
                      (commit_i && (wb_waddr_i == iss_waddr_i));
        iss_fire    = iss_valid_i && iss_ready_o;

        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_step(cnt_q[r],
                                iss_fire && (iss_waddr_i == REG_AW'(r)),
                                commit_i && (wb_waddr_i == REG_AW'(r)));
        end

        // The last outstanding write committing now is served by the bypass.
        for (int q = 0; q < 2; q++) begin
            busy_o[q] = (cnt_q[qaddr_i[q]] != '0) &&
                        !((cnt_q[qaddr_i[q]] == CNT_ONE) && commit_i &&
                          (wb_waddr_i == qaddr_i[q]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Write-back stage: commits results and flags into the register file,
// serves two bypassed read ports and tracks pending writes for decode.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = regfile_wb_pkg::DW,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst,
    regfile_wb_if.slave  bus
);

    logic [DW-1:0]      regs_q [NREGS];
    logic [DW-1:0]      regs_d [NREGS];
    logic [FLAGS_W-1:0] flags_q;
    logic [FLAGS_W-1:0] flags_d;
    logic               commit;
    logic [1:0]         busy;

    assign commit = bus.wb_enable_in & bus.wb_we_in;

    always_comb begin
        regs_d = regs_q;
        if (commit) regs_d[bus.wb_waddr_in] = bus.wb_result_in;
        flags_d = (bus.wb_enable_in && bus.wb_flags_we_in) ? bus.wb_flags_in : flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    // Same-cycle bypass so a read never lags the commit it races with.
    assign bus.rdata_a_out = (commit && (bus.raddr_a_in == bus.wb_waddr_in)) ?
                             bus.wb_result_in : regs_q[bus.raddr_a_in];
    assign bus.rdata_b_out = (commit && (bus.raddr_b_in == bus.wb_waddr_in)) ?
                             bus.wb_result_in : regs_q[bus.raddr_b_in];
    assign bus.flags_out   = flags_q;

    reg_scoreboard #(
        .NREGS (NREGS),
        .CW    (CW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .commit_i    (commit),
        .wb_waddr_i  (bus.wb_waddr_in),
        .iss_valid_i (bus.iss_valid_in),
        .iss_waddr_i (bus.iss_waddr_in),
        .iss_ready_o (bus.iss_ready_out),
        .qaddr_i     ({bus.raddr_b_in, bus.raddr_a_in}),
        .busy_o      (busy)
    );

    assign bus.busy_a_out = busy[0];
    assign bus.busy_b_out = busy[1];

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset state, bypass, scoreboard limits,
// flags-only commits and reset in the middle of outstanding writes.
module tb_regfile_wb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    regfile_wb_if bus();

    regfile_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic we, input logic fwe,
                      input logic [3:0] addr, input logic [23:0] data, input logic [3:0] fl);
        bus.wb_enable_in   = en;
        bus.wb_we_in       = we;
        bus.wb_flags_we_in = fwe;
        bus.wb_waddr_in    = addr;
        bus.wb_result_in   = data;
        bus.wb_flags_in    = fl;
    endtask

    task automatic iss(input logic v, input logic [3:0] addr);
        bus.iss_valid_in = v;
        bus.iss_waddr_in = addr;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        iss(1'b0, 4'd0);
        bus.raddr_a_in = 4'd0;
        bus.raddr_b_in = 4'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state across all addresses
        for (int i = 0; i < 16; i++) begin
            bus.raddr_a_in = 4'(i);
            bus.raddr_b_in = 4'(15 - i);
            #1;
            check($sformatf("rst_rdata_a[%0d]", i), 32'(bus.rdata_a_out), 32'h0);
            check($sformatf("rst_rdata_b[%0d]", 15 - i), 32'(bus.rdata_b_out), 32'h0);
            check($sformatf("rst_busy_a[%0d]", i), 32'(bus.busy_a_out), 32'h0);
            check($sformatf("rst_busy_b[%0d]", 15 - i), 32'(bus.busy_b_out), 32'h0);
        end
        check("rst_ready", 32'(bus.iss_ready_out), 32'h1);
        check("rst_flags", 32'(bus.flags_out), 32'h0);

        // Bypass on R5, then the registered value
        wb(1'b1, 1'b1, 1'b0, 4'd5, 24'hABCDEF, 4'h0);
        bus.raddr_a_in = 4'd5;
        bus.raddr_b_in = 4'd4;
        #1;
        check("r5_bypass", 32'(bus.rdata_a_out), 32'hABCDEF);
        check("r5_err_busy", 32'(bus.busy_a_out), 32'h0);
        check("r4_untouched", 32'(bus.rdata_b_out), 32'h0);
        tick();
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        #1;
        check("r5_next", 32'(bus.rdata_a_out), 32'hABCDEF);
        check("r5_busy_next", 32'(bus.busy_a_out), 32'h0);

        // Three issues to R3 fill its counter
        bus.raddr_a_in = 4'd3;
        iss(1'b1, 4'd3);
        #1;
        check("r3_busy_before", 32'(bus.busy_a_out), 32'h0);
        check("r3_ready0", 32'(bus.iss_ready_out), 32'h1);
        tick();
        #1;
        check("r3_busy_after1", 32'(bus.busy_a_out), 32'h1);
        check("r3_ready1", 32'(bus.iss_ready_out), 32'h1);
        tick();
        tick();
        #1;
        check("r3_full", 32'(bus.iss_ready_out), 32'h0);
        wb(1'b1, 1'b1, 1'b0, 4'd3, 24'h333333, 4'h0);
        #1;
        check("r3_commit_ready", 32'(bus.iss_ready_out), 32'h1);
        check("r3_commit_busy", 32'(bus.busy_a_out), 32'h1);
        check("r3_commit_bypass", 32'(bus.rdata_a_out), 32'h333333);
        tick();
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        #1;
        check("r3_still_full", 32'(bus.iss_ready_out), 32'h0);
        check("r3_still_busy", 32'(bus.busy_a_out), 32'h1);

        // Drain R3: 3 -> 2 -> 1, last commit clears busy in the same cycle
        iss(1'b0, 4'd3);
        wb(1'b1, 1'b1, 1'b0, 4'd3, 24'h333334, 4'h0);
        tick();
        #1;
        check("r3_busy_cnt2", 32'(bus.busy_a_out), 32'h1);
        tick();
        #1;
        check("r3_last_commit_busy", 32'(bus.busy_a_out), 32'h0);
        tick();
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        #1;
        check("r3_drained_busy", 32'(bus.busy_a_out), 32'h0);
        check("r3_drained_ready", 32'(bus.iss_ready_out), 32'h1);
        check("r3_value", 32'(bus.rdata_a_out), 32'h333334);

        // Issue R4 and commit R6 in the same cycle
        iss(1'b1, 4'd6);
        tick();
        iss(1'b1, 4'd4);
        wb(1'b1, 1'b1, 1'b0, 4'd6, 24'h666666, 4'h0);
        bus.raddr_a_in = 4'd4;
        bus.raddr_b_in = 4'd6;
        #1;
        check("r6_commit_busy", 32'(bus.busy_b_out), 32'h0);
        check("r4_pre_busy", 32'(bus.busy_a_out), 32'h0);
        tick();
        iss(1'b0, 4'd0);
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        #1;
        check("r4_inc", 32'(bus.busy_a_out), 32'h1);
        check("r6_dec", 32'(bus.busy_b_out), 32'h0);
        check("r6_value", 32'(bus.rdata_b_out), 32'h666666);

        // R7 with one outstanding write
        iss(1'b1, 4'd7);
        tick();
        iss(1'b0, 4'd0);
        bus.raddr_b_in = 4'd7;
        #1;
        check("r7_busy", 32'(bus.busy_b_out), 32'h1);
        wb(1'b1, 1'b1, 1'b0, 4'd7, 24'h000042, 4'h0);
        #1;
        check("r7_commit_busy", 32'(bus.busy_b_out), 32'h0);
        check("r7_commit_bypass", 32'(bus.rdata_b_out), 32'h000042);
        tick();
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        #1;
        check("r7_after_busy", 32'(bus.busy_b_out), 32'h0);
        check("r7_after_value", 32'(bus.rdata_b_out), 32'h000042);

        // Flags-only commit leaves R5 and its pending count alone
        iss(1'b1, 4'd5);
        tick();
        iss(1'b0, 4'd0);
        bus.raddr_a_in = 4'd5;
        wb(1'b1, 1'b0, 1'b1, 4'd5, 24'h111111, 4'b1010);
        #1;
        check("flags_no_bypass", 32'(bus.flags_out), 32'h0);
        check("flags_no_reg_bypass", 32'(bus.rdata_a_out), 32'hABCDEF);
        tick();
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        #1;
        check("flags_written", 32'(bus.flags_out), 32'hA);
        check("flags_r5_kept", 32'(bus.rdata_a_out), 32'hABCDEF);
        check("flags_r5_busy", 32'(bus.busy_a_out), 32'h1);

        // Disabled slot: all wb fields ignored
        wb(1'b0, 1'b1, 1'b1, 4'd5, 24'h999999, 4'b0101);
        #1;
        check("dis_no_bypass", 32'(bus.rdata_a_out), 32'hABCDEF);
        tick();
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        #1;
        check("dis_flags", 32'(bus.flags_out), 32'hA);
        check("dis_reg", 32'(bus.rdata_a_out), 32'hABCDEF);
        check("dis_busy", 32'(bus.busy_a_out), 32'h1);

        // Reset with R2 pending; reset also overrides a commit and an issue
        iss(1'b1, 4'd2);
        tick();
        tick();
        iss(1'b0, 4'd0);
        bus.raddr_a_in = 4'd2;
        bus.raddr_b_in = 4'd9;
        #1;
        check("r2_busy_pre_rst", 32'(bus.busy_a_out), 32'h1);
        rst = 1'b1;
        wb(1'b1, 1'b1, 1'b1, 4'd9, 24'h999999, 4'hF);
        iss(1'b1, 4'd2);
        tick();
        rst = 1'b0;
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        iss(1'b0, 4'd2);
        #1;
        check("rst_r2_busy", 32'(bus.busy_a_out), 32'h0);
        check("rst_r2_ready", 32'(bus.iss_ready_out), 32'h1);
        check("rst_r9_no_commit", 32'(bus.rdata_b_out), 32'h0);
        check("rst_flags_cleared", 32'(bus.flags_out), 32'h0);
        check("rst_r2_value", 32'(bus.rdata_a_out), 32'h0);

        // Stale commit to R2 after reset: written, count stays zero
        wb(1'b1, 1'b1, 1'b0, 4'd2, 24'h222222, 4'h0);
        #1;
        check("stale_r2_busy", 32'(bus.busy_a_out), 32'h0);
        check("stale_r2_bypass", 32'(bus.rdata_a_out), 32'h222222);
        tick();
        wb(1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 4'h0);
        #1;
        check("stale_r2_busy_next", 32'(bus.busy_a_out), 32'h0);
        check("stale_r2_value", 32'(bus.rdata_a_out), 32'h222222);
        iss(1'b1, 4'd2);
        tick();
        iss(1'b0, 4'd0);
        #1;
        check("stale_r2_count_one", 32'(bus.busy_a_out), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
